uart_rx: RTL

UART receiver, the receive-side companion of the existing 8N1 UART transmitter in the 8051 serial port path.
- Samples an asynchronous serial line.
- Recovers frames of 1 start bit, 8 data bits (LSB first), no parity and 1 stop bit.
- Presents the received byte with a one-cycle valid strobe.
- Flags framing errors.
- Its outputs feed SBUF/RI logic in the serial port block.

---
 rtl/uart_rx.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, valid/framing-error pulses.
// Optional `UART_RX_MAJORITY_EN: 2-of-3 majority vote at every sample point.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 1085
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_serial,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam logic [10:0] HALF = 11'((CLKS_PER_BIT - 1) / 2);
  localparam logic [10:0] LAST = 11'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    s_idle,
    s_start_bit,
    s_data_bits,
    s_stop_bit,
    s_cleanup,
    s_wait_high
  } state_t;

  state_t      state, state_n;
  logic        rx_meta, rx_s;
  logic        sample;
  logic [10:0] clock_count, clock_count_n;
  logic [2:0]  bit_index, bit_index_n;
  logic [7:0]  shift, shift_n;
  logic [7:0]  byte_n;
  logic        valid_n, frame_err_n;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx_serial;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // The two stored samples plus the live rx_s form the 3-deep window, so voting costs no latency.
  logic [1:0] rx_hist;

  always_ff @(posedge i_clk) begin
    if (i_rst) rx_hist <= '1;
    else       rx_hist <= {rx_hist[0], rx_s};
  end

  assign sample = (rx_s & rx_hist[0]) | (rx_s & rx_hist[1]) | (rx_hist[0] & rx_hist[1]);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= s_idle;
      clock_count <= '0;
      bit_index   <= '0;
      shift       <= '0;
      o_byte      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_n;
      clock_count <= clock_count_n;
      bit_index   <= bit_index_n;
      shift       <= shift_n;
      o_byte      <= byte_n;
      o_valid     <= valid_n;
      o_frame_err <= frame_err_n;
    end
  end

  // Pulses default low each cycle, which is what clears them in s_cleanup/s_wait_high.
  always_comb begin
    state_n       = state;
    clock_count_n = clock_count;
    bit_index_n   = bit_index;
    shift_n       = shift;
    byte_n        = o_byte;
    valid_n       = 1'b0;
    frame_err_n   = 1'b0;
    case (state)
      s_idle: begin
        clock_count_n = '0;
        bit_index_n   = '0;
        if (!rx_s) state_n = s_start_bit;
      end
      s_start_bit: begin
        if (clock_count == HALF) begin
          clock_count_n = '0;
          state_n       = sample ? s_idle : s_data_bits;
        end else begin
          clock_count_n = clock_count + 11'd1;
        end
      end
      s_data_bits: begin
        if (clock_count == LAST) begin
          clock_count_n      = '0;
          shift_n[bit_index] = sample;
          if (bit_index < 3'd7) begin
            bit_index_n = bit_index + 3'd1;
          end else begin
            bit_index_n = '0;
            state_n     = s_stop_bit;
          end
        end else begin
          clock_count_n = clock_count + 11'd1;
        end
      end
      s_stop_bit: begin
        if (clock_count == LAST) begin
          clock_count_n = '0;
          if (sample) begin
            byte_n  = shift;
            valid_n = 1'b1;
            state_n = s_cleanup;
          end else begin
            frame_err_n = 1'b1;
            state_n     = s_wait_high;
          end
        end else begin
          clock_count_n = clock_count + 11'd1;
        end
      end
      s_cleanup:   state_n = s_idle;
      s_wait_high: if (rx_s) state_n = s_idle;
      default:     state_n = s_idle;
    endcase
  end

  assign o_busy = (state != s_idle);

endmodule
